reg_io_bridge: RTL and testbench

REG_IO_BRIDGE -- requirements
Module: reg_io_bridge

---
 rtl/types_pkg.sv | 15 +
 rtl/reg_io_bridge_if.sv | 18 +
 rtl/io_fifo.sv | 74 +++++++
 rtl/reg_io_bridge.sv | 98 +++++++++
 tb/tb_reg_io_bridge.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared data and FIFO pointer types for the register I/O bridge
//
// Purpose: one place for the register-file data width and the FIFO pointer/occupancy type.
// FIFO_PTR is deliberately wider than any practical FIFO index. Pointers are masked down to
// log2(FIFO_DEPTH) bits. The occupancy count keeps the spare high bits, so a full FIFO
// (count == FIFO_DEPTH) is never confused with an empty one (count == 0).
package types_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int FIFO_PTR_WIDTH = 16;

  typedef logic [DATA_WIDTH-1:0]     DATA_BUS;
  typedef logic [FIFO_PTR_WIDTH-1:0] FIFO_PTR;

endpackage

// File: rtl/reg_io_bridge_if.sv
// rtl/reg_io_bridge_if.sv - valid/ready output stream carrying captured a0 values
//
// Signals:
//   out_data  - value at the FIFO head
//   out_valid - FIFO holds at least one entry
//   out_ready - consumer accepts out_data this cycle
// Modports: master (bridge side), slave (consumer side).
interface reg_io_bridge_if;
  import types_pkg::*;

  DATA_BUS out_data;
  logic    out_valid;
  logic    out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/io_fifo.sv
// rtl/io_fifo.sv - small synchronous FIFO for captured a0 values
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   push       - write request. It is accepted when not full, or when full but popping.
//   push_data  - value to write
//   pop        - read request. It is ignored while empty.
//   pop_data   - head entry. It is 0 while empty, so it is also 0 during reset.
//   full       - count == FIFO_DEPTH
//   empty      - count == 0
// FIFO_DEPTH must be a power of two and at least 2.
module io_fifo
  import types_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  DATA_BUS push_data,
  input  logic    pop,
  output DATA_BUS pop_data,
  output logic    full,
  output logic    empty
);

  localparam int      AW       = $clog2(FIFO_DEPTH);
  localparam FIFO_PTR PTR_MASK = FIFO_PTR'(FIFO_DEPTH - 1);
  localparam FIFO_PTR DEPTH_P  = FIFO_PTR'(FIFO_DEPTH);

  DATA_BUS mem [FIFO_DEPTH];
  FIFO_PTR wr_ptr;
  FIFO_PTR rd_ptr;
  FIFO_PTR count;
  logic    do_push;
  logic    do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_P);
  assign do_pop  = pop & ~empty;
  // When full, a pop in the same cycle frees the slot being written. This works because
  // wr_ptr == rd_ptr, the head is read combinationally, and the write lands on the edge.
  assign do_push = push & (~full | do_pop);

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // The storage array is not reset. Only the pointers and the count carry meaning.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr + FIFO_PTR'(1)) & PTR_MASK;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr + FIFO_PTR'(1)) & PTR_MASK;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + FIFO_PTR'(1);
        2'b01:   count <= count - FIFO_PTR'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reg_io_bridge.sv
// rtl/reg_io_bridge.sv - seconds counter into x31 plus change-capture FIFO for a0
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   a0         - live value of register x10
//   x31        - seconds count driven into register x31
//   tick       - one-cycle pulse in the cycle before x31 increments
//   io         - valid/ready stream of captured a0 values (master side)
//   ovf_clr    - clear the sticky overflow flag
//   overflow   - sticky flag. It is set when a captured a0 value was dropped.
module reg_io_bridge
  import types_pkg::*;
#(
  parameter int TICK_PERIOD = 50_000_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  DATA_BUS         a0,
  output DATA_BUS         x31,
  output logic            tick,
  reg_io_bridge_if.master io,
  input  logic            ovf_clr,
  output logic            overflow
);

  localparam int PW = $clog2(TICK_PERIOD);
  typedef logic [PW-1:0] presc_t;
  localparam presc_t PRESC_LAST = presc_t'(TICK_PERIOD - 1);

  presc_t  presc;
  DATA_BUS a0_q;
  DATA_BUS head;
  logic    change;
  logic    pop_fire;
  logic    fifo_full;
  logic    fifo_empty;
  logic    drop;

  // tick is decoded from the prescaler rather than registered. It is therefore 0 while
  // reset holds presc at 0, and x31 steps on the same edge that wraps the prescaler.
  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      x31   <= '0;
    end else if (tick) begin
      presc <= '0;
      x31   <= x31 + DATA_BUS'(1);
    end else begin
      presc <= presc + presc_t'(1);
    end
  end

  // a0_q resets to 0, so a nonzero a0 right after reset is captured on the first edge.
  assign change = (a0 != a0_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_q <= '0;
    end else if (change) begin
      a0_q <= a0;
    end
  end

  assign pop_fire = io.out_valid & io.out_ready;
  // A push into a full FIFO is lost only when no pop frees a slot in the same cycle.
  assign drop     = change & fifo_full & ~pop_fire;

  // If a drop and a clear happen in the same cycle, the set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  io_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (change),
    .push_data (a0),
    .pop       (pop_fire),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign io.out_valid = ~fifo_empty;
  assign io.out_data  = head;

endmodule

// File: tb/tb_reg_io_bridge.sv
// tb/tb_reg_io_bridge.sv - scoreboard bench for reg_io_bridge (TICK_PERIOD=4, FIFO_DEPTH=4)
module tb_reg_io_bridge;
  import types_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n;
  DATA_BUS a0;
  DATA_BUS x31;
  logic    tick;
  logic    ovf_clr;
  logic    overflow;

  int      n_cmp = 0;
  int      n_bad = 0;
  DATA_BUS exp_q[$];

  always #5 clk = ~clk;

  reg_io_bridge_if bus ();

  reg_io_bridge #(
    .TICK_PERIOD (4),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a0       (a0),
    .x31      (x31),
    .tick     (tick),
    .io       (bus),
    .ovf_clr  (ovf_clr),
    .overflow (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Monitor: every accepted beat is compared against the oldest expected value.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got %0h expected no entry", bus.out_data);
      end else begin
        check("pop_data", bus.out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a0 = '0;
    ovf_clr = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    mid();
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_x31", x31, 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_overflow", 32'(overflow), 0);

    // Tick cadence and single capture of a0=5
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      if (c == 10) begin
        a0 = 32'd5;
        exp_q.push_back(32'd5);
      end
      mid();
      check($sformatf("tick_c%0d", c), 32'(tick), 32'((c % 4) == 0));
      check($sformatf("x31_c%0d", c), x31, 32'((c - 1) / 4));
      if (c == 11) check("valid_after_change", 32'(bus.out_valid), 1);
      if (c == 12) check("valid_after_pop", 32'(bus.out_valid), 0);
      step();
    end

    // Fill with 1..4, then drop 5 and 6
    bus.out_ready = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      a0 = 32'(v);
      if (v <= 4) exp_q.push_back(32'(v));
      step();
    end
    mid();
    check("ovf_after_drop", 32'(overflow), 1);
    check("full_valid", 32'(bus.out_valid), 1);
    check("head_stable", bus.out_data, 1);
    step();

    // Drop and clear in the same cycle, then clear alone
    a0 = 32'd7;
    ovf_clr = 1'b1;
    step();
    mid();
    check("ovf_set_wins", 32'(overflow), 1);
    step();
    ovf_clr = 1'b0;
    mid();
    check("ovf_cleared", 32'(overflow), 0);

    bus.out_ready = 1'b1;
    repeat (5) step();
    mid();
    check("drained_valid", 32'(bus.out_valid), 0);
    step();

    // Full FIFO with push and pop in the same cycle
    bus.out_ready = 1'b0;
    for (int v = 11; v <= 14; v++) begin
      a0 = 32'(v);
      exp_q.push_back(32'(v));
      step();
    end
    bus.out_ready = 1'b1;
    a0 = 32'd9;
    exp_q.push_back(32'd9);
    step();
    bus.out_ready = 1'b0;
    a0 = 32'd10;
    mid();
    check("no_ovf_pushpop_full", 32'(overflow), 0);
    step();
    mid();
    check("still_full_after_pushpop", 32'(overflow), 1);
    step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) step();
    mid();
    check("drained_valid2", 32'(bus.out_valid), 0);
    check("ovf_clear2", 32'(overflow), 0);
    step();

    // Reset mid-operation with 3 entries queued
    bus.out_ready = 1'b0;
    for (int v = 21; v <= 23; v++) begin
      a0 = 32'(v);
      exp_q.push_back(32'(v));
      step();
    end
    step();
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    check("midrst_valid", 32'(bus.out_valid), 0);
    check("midrst_data", bus.out_data, 0);
    check("midrst_x31", x31, 0);
    check("midrst_overflow", 32'(overflow), 0);
    check("midrst_tick", 32'(tick), 0);
    repeat (2) step();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.push_back(32'd23);
    for (int c = 1; c <= 5; c++) begin
      mid();
      check($sformatf("post_rst_tick_c%0d", c), 32'(tick), 32'(c == 4));
      if (c == 2) check("post_rst_first_push", 32'(bus.out_valid), 1);
      if (c == 5) check("post_rst_x31", x31, 1);
      step();
    end

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
